line_read_scheduler: RTL and testbench
======================================

Name: line_read_scheduler

Overview:
- Sequences line-granular reads from the pixel input FIFO into the bilinear scaler in the biliner_clk_in domain.
- Primes the FIFO once per frame, then issues one H_PIX-long read burst per line. A burst starts only when the FIFO holds a full line and the downstream line buffer has a free slot (credit).
- Generates pixel-aligned line/frame markers and sticky error flags for debug.

Parameters:
- H_PIX, 640, pixels per line (burst length); must be ≥ 2.
- V_PIX, 480, lines per frame.
- START_LEVEL, 3000, FIFO read-side word count required before the first line of each frame.
- CREDITS, 2, number of downstream line buffers; 1..15.
- CNT_W, 16, width of the FIFO data-count input.

Ports:
- biliner_clk_in  in  1  scaler clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- enable  in  1  start permission (ADV7611 config done); sampled only in IDLE/PRIME/LINE_WAIT.
- fifo_rd_count  in  CNT_W  FIFO read-side data count.
- fifo_empty  in  1  FIFO empty flag.
- line_done_i  in  1  one-cycle pulse: downstream released one line buffer.
- fifo_rd_en  out  1  FIFO read enable (registered).
- pix_valid  out  1  fifo_rd_en delayed 1 cycle; qualifies FIFO rdata.
- line_start  out  1  pulse with first pix_valid of each line.
- line_end  out  1  pulse with last pix_valid of each line.
- frame_start  out  1  line_start of line 0.
- frame_end  out  1  line_end of line V_PIX-1.
- line_cnt  out  11  index of the line being or last burst; 0..V_PIX-1.
- credit_cnt  out  4  free downstream buffers.
- underflow_err  out  1  sticky: fifo_rd_en high while fifo_empty high.
- credit_err  out  1  sticky: line_done_i received with credit_cnt==CREDITS.
- state_o  out  2  current state encoding.

Behaviour:
- Reset values:
  - state=IDLE; credit_cnt=CREDITS.
  - All other outputs 0, including line_cnt and both error flags.
  - Internal h_cnt=0.
- States (2'd0..2'd3): IDLE, PRIME, LINE_WAIT, BURST.
- IDLE:
  - Goes to PRIME when enable=1.
- PRIME:
  - Goes to LINE_WAIT when fifo_rd_count ≥ START_LEVEL.
  - Returns to IDLE if enable=0.
- LINE_WAIT:
  - Goes to BURST when fifo_rd_count ≥ H_PIX and credit_cnt > 0 in the same cycle.
  - Returns to IDLE if enable=0; this check has priority over starting a burst.
- On the LINE_WAIT→BURST edge:
  - fifo_rd_en←1, h_cnt←0.
  - credit_cnt decrements.
- BURST, every cycle:
  - h_cnt increments.
  - On the edge where h_cnt==H_PIX-1: fifo_rd_en←0, h_cnt←0.
  - Net effect: fifo_rd_en is high for exactly H_PIX consecutive cycles.
- BURST is never aborted; enable is ignored until the line completes.
- End of burst:
  - If line_cnt==V_PIX-1: line_cnt←0 and state→PRIME (re-prime each frame).
  - Otherwise: line_cnt increments and state→LINE_WAIT.
- Consecutive bursts are separated by ≥ 1 idle cycle (the LINE_WAIT evaluation cycle).
- pix_valid is fifo_rd_en registered once.
- line_start/line_end/frame_start/frame_end are single-cycle pulses aligned to pix_valid, not to fifo_rd_en.
- Credits:
  - Decrement at burst start; +1 on line_done_i.
  - Simultaneous burst start and line_done_i: credit_cnt unchanged.
  - line_done_i at credit_cnt==CREDITS: count held, credit_err←1.
  - Credits persist across frames; they are reset only by sys_rst.
- underflow_err sets when fifo_rd_en=1 and fifo_empty=1 in the same cycle. The burst still completes with full length.
- Both error flags clear only on sys_rst.
- sys_rst asserted mid-burst: next edge restores all reset values, including fifo_rd_en=0 and pix_valid=0.

Test Plan:
- Reset, enable=1, fifo_rd_count=2999 held → state stays PRIME, fifo_rd_en=0. Raise count to 3000 → LINE_WAIT one edge later, first fifo_rd_en next cycle.
- Count=3000, credits free → fifo_rd_en high exactly 640 cycles. pix_valid is the same pulse shifted +1 cycle. line_start on the first pix_valid, line_end on the 640th. credit_cnt 2→1.
- No line_done_i after two lines → credit_cnt=0, stays in LINE_WAIT with fifo_rd_count=4000. Pulse line_done_i → next burst starts 2 cycles later.
- Run 480 lines with line_done_i after each → frame_start with line 0, frame_end with line 479. line_cnt wraps to 0, state→PRIME. Next frame waits for count ≥ 3000.
- Force fifo_empty=1 during cycle 100 of a burst → underflow_err=1 and stays 1. Burst still 640 cycles. Pulse line_done_i at credit_cnt=2 → credit_err=1, credit_cnt stays 2.
- Drop enable mid-burst → line completes, then IDLE. Assert sys_rst at burst cycle 300 → fifo_rd_en=0 and credit_cnt=2 on the next edge, errors cleared.

Source files
------------

// File: rtl/line_read_scheduler.sv
// Line-granular FIFO read sequencer for the bilinear scaler: primes once per frame,
// then issues one H_PIX-long read burst per line gated by FIFO level and downstream credits.
module line_read_scheduler #(
    parameter int H_PIX       = 640,
    parameter int V_PIX       = 480,
    parameter int START_LEVEL = 3000,
    parameter int CREDITS     = 2,
    parameter int CNT_W       = 16
) (
    input  logic             biliner_clk_in,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] fifo_rd_count,
    input  logic             fifo_empty,
    input  logic             line_done_i,
    output logic             fifo_rd_en,
    output logic             pix_valid,
    output logic             line_start,
    output logic             line_end,
    output logic             frame_start,
    output logic             frame_end,
    output logic [10:0]      line_cnt,
    output logic [3:0]       credit_cnt,
    output logic             underflow_err,
    output logic             credit_err,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRIME     = 2'd1,
        S_LINE_WAIT = 2'd2,
        S_BURST     = 2'd3
    } state_t;

    localparam int               HW        = $clog2(H_PIX);
    localparam logic [HW-1:0]    H_LAST    = HW'(H_PIX - 1);
    localparam logic [10:0]      V_LAST    = 11'(V_PIX - 1);
    localparam logic [3:0]       CRED_MAX  = 4'(CREDITS);
    localparam logic [CNT_W-1:0] PRIME_LVL = CNT_W'(START_LEVEL);
    localparam logic [CNT_W-1:0] LINE_LVL  = CNT_W'(H_PIX);

    state_t          r_state;
    logic [HW-1:0]   r_h_cnt;
    logic [10:0]     r_line_cnt;
    logic [3:0]      r_credit;
    logic            r_underflow;
    logic            r_credit_err;
    logic            r_rd_en_p0;
    logic            r_vld_p1;
    logic            r_ls_p1;
    logic            r_le_p1;
    logic            r_fs_p1;
    logic            r_fe_p1;

    logic            w_burst_go;
    logic            w_first;
    logic            w_last;
    logic            w_credit_over;

    // A release while every buffer is already free is a protocol error; the count saturates.
    function automatic logic [3:0] credit_next(input logic [3:0] cur, input logic take,
                                               input logic give);
        logic [3:0] nxt;
        nxt = cur;
        if (take && !give)
            nxt = cur - 4'd1;
        else if (give && !take && cur != CRED_MAX)
            nxt = cur + 4'd1;
        return nxt;
    endfunction

    assign w_burst_go    = (r_state == S_LINE_WAIT) && enable &&
                           (fifo_rd_count >= LINE_LVL) && (r_credit != 4'd0);
    assign w_first       = r_rd_en_p0 && (r_h_cnt == '0);
    assign w_last        = r_rd_en_p0 && (r_h_cnt == H_LAST);
    assign w_credit_over = line_done_i && !w_burst_go && (r_credit == CRED_MAX);

    always_ff @(posedge biliner_clk_in) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_h_cnt      <= '0;
            r_line_cnt   <= '0;
            r_credit     <= CRED_MAX;
            r_underflow  <= 1'b0;
            r_credit_err <= 1'b0;
            r_rd_en_p0   <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_ls_p1      <= 1'b0;
            r_le_p1      <= 1'b0;
            r_fs_p1      <= 1'b0;
            r_fe_p1      <= 1'b0;
        end else begin
            // p0 -> p1: markers are decoded from the read strobe and land with the FIFO data
            r_vld_p1 <= r_rd_en_p0;
            r_ls_p1  <= w_first;
            r_le_p1  <= w_last;
            r_fs_p1  <= w_first && (r_line_cnt == 11'd0);
            r_fe_p1  <= w_last && (r_line_cnt == V_LAST);

            if (r_rd_en_p0 && fifo_empty)
                r_underflow <= 1'b1;
            if (w_credit_over)
                r_credit_err <= 1'b1;
            r_credit <= credit_next(r_credit, w_burst_go, line_done_i);

            unique case (r_state)
                S_IDLE: begin
                    if (enable)
                        r_state <= S_PRIME;
                end
                S_PRIME: begin
                    if (!enable)
                        r_state <= S_IDLE;
                    else if (fifo_rd_count >= PRIME_LVL)
                        r_state <= S_LINE_WAIT;
                end
                S_LINE_WAIT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_burst_go) begin
                        r_state    <= S_BURST;
                        r_rd_en_p0 <= 1'b1;
                        r_h_cnt    <= '0;
                    end
                end
                S_BURST: begin
                    if (r_h_cnt == H_LAST) begin
                        r_rd_en_p0 <= 1'b0;
                        r_h_cnt    <= '0;
                        if (r_line_cnt == V_LAST) begin
                            r_line_cnt <= '0;
                            r_state    <= S_PRIME;
                        end else begin
                            r_line_cnt <= r_line_cnt + 11'd1;
                            r_state    <= S_LINE_WAIT;
                        end
                    end else begin
                        r_h_cnt <= r_h_cnt + HW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_rd_en    = r_rd_en_p0;
    assign pix_valid     = r_vld_p1;
    assign line_start    = r_ls_p1;
    assign line_end      = r_le_p1;
    assign frame_start   = r_fs_p1;
    assign frame_end     = r_fe_p1;
    assign line_cnt      = r_line_cnt;
    assign credit_cnt    = r_credit;
    assign underflow_err = r_underflow;
    assign credit_err    = r_credit_err;
    assign state_o       = r_state;

endmodule

// File: tb/tb_line_read_scheduler.sv
// Directed bench for line_read_scheduler; V_PIX reduced to 4 so whole frames fit a short run.
module tb_line_read_scheduler;

    localparam int H = 640;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic [15:0] fifo_rd_count;
    logic        fifo_empty;
    logic        line_done_i;
    logic        fifo_rd_en, pix_valid, line_start, line_end, frame_start, frame_end;
    logic [10:0] line_cnt;
    logic [3:0]  credit_cnt;
    logic        underflow_err, credit_err;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    int b_rd, b_pv, b_shift, b_ls_cnt, b_ls_ok, b_le_cnt, b_le_ok, b_fs, b_fe;

    line_read_scheduler #(
        .H_PIX(H), .V_PIX(V), .START_LEVEL(3000), .CREDITS(2), .CNT_W(16)
    ) dut (
        .biliner_clk_in(clk),
        .sys_rst(sys_rst),
        .enable(enable),
        .fifo_rd_count(fifo_rd_count),
        .fifo_empty(fifo_empty),
        .line_done_i(line_done_i),
        .fifo_rd_en(fifo_rd_en),
        .pix_valid(pix_valid),
        .line_start(line_start),
        .line_end(line_end),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .line_cnt(line_cnt),
        .credit_cnt(credit_cnt),
        .underflow_err(underflow_err),
        .credit_err(credit_err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_done();
        line_done_i = 1'b1;
        tick();
        line_done_i = 1'b0;
    endtask

    // Follows one burst from its first fifo_rd_en cycle until pix_valid drops.
    task automatic run_burst();
        int  pvi;
        logic prev;
        b_rd = 0; b_shift = 0; b_ls_cnt = 0; b_ls_ok = 0;
        b_le_cnt = 0; b_le_ok = 0; b_fs = 0; b_fe = 0;
        pvi = 0; prev = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (pvi > 0 && !pix_valid) break;
            if (fifo_rd_en) b_rd++;
            if (pix_valid !== prev) b_shift++;
            if (pix_valid) pvi++;
            if (line_start) begin
                b_ls_cnt++;
                if (pix_valid && pvi == 1) b_ls_ok = 1;
            end
            if (line_end) begin
                b_le_cnt++;
                if (pix_valid && pvi == H) b_le_ok = 1;
            end
            if (frame_start) b_fs++;
            if (frame_end) b_fe++;
            prev = fifo_rd_en;
            tick();
        end
        b_pv = pvi;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; enable = 1'b0; fifo_rd_count = '0; fifo_empty = 1'b0; line_done_i = 1'b0;
        tick(2);
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++; if (credit_cnt !== 4'd2) begin errors++; $display("FAIL reset_credit got %0d exp 2", credit_cnt); end
        checks++; if (fifo_rd_en !== 1'b0 || pix_valid !== 1'b0) begin errors++; $display("FAIL reset_rd got %b/%b exp 0/0", fifo_rd_en, pix_valid); end
        checks++; if (line_cnt !== 11'd0) begin errors++; $display("FAIL reset_line got %0d exp 0", line_cnt); end
        checks++; if ({underflow_err, credit_err} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {underflow_err, credit_err}); end
        sys_rst = 1'b0;
    endtask

    task automatic test_prime();
        enable = 1'b1; fifo_rd_count = 16'd2999;
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL prime_enter got %0d exp 1", state_o); end
        tick(20);
        checks++; if (state_o !== 2'd1 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL prime_hold got st=%0d rd=%b exp st=1 rd=0", state_o, fifo_rd_en); end
        fifo_rd_count = 16'd3000;
        tick();
        checks++; if (state_o !== 2'd2 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL prime_lw got st=%0d rd=%b exp st=2 rd=0", state_o, fifo_rd_en); end
        tick();
        checks++; if (fifo_rd_en !== 1'b1 || credit_cnt !== 4'd1) begin errors++; $display("FAIL first_rd got rd=%b cr=%0d exp rd=1 cr=1", fifo_rd_en, credit_cnt); end
    endtask

    task automatic test_burst();
        run_burst();
        checks++; if (b_rd !== H || b_pv !== H) begin errors++; $display("FAIL burst_len got rd=%0d pv=%0d exp %0d", b_rd, b_pv, H); end
        checks++; if (b_shift !== 0) begin errors++; $display("FAIL pv_shift got %0d bad cycles exp 0", b_shift); end
        checks++; if (b_ls_cnt !== 1 || b_ls_ok !== 1) begin errors++; $display("FAIL line_start got cnt=%0d ok=%0d exp 1/1", b_ls_cnt, b_ls_ok); end
        checks++; if (b_le_cnt !== 1 || b_le_ok !== 1) begin errors++; $display("FAIL line_end got cnt=%0d ok=%0d exp 1/1", b_le_cnt, b_le_ok); end
        checks++; if (b_fs !== 1 || b_fe !== 0) begin errors++; $display("FAIL frame_l0 got fs=%0d fe=%0d exp 1/0", b_fs, b_fe); end
        checks++; if (line_cnt !== 11'd1 || fifo_rd_en !== 1'b1) begin errors++; $display("FAIL line1_go got lc=%0d rd=%b exp 1/1", line_cnt, fifo_rd_en); end
    endtask

    task automatic test_credit();
        run_burst();
        checks++; if (b_rd !== H || b_fs !== 0) begin errors++; $display("FAIL line1_len got rd=%0d fs=%0d exp %0d/0", b_rd, b_fs, H); end
        checks++; if (credit_cnt !== 4'd0 || line_cnt !== 11'd2) begin errors++; $display("FAIL credit_out got cr=%0d lc=%0d exp 0/2", credit_cnt, line_cnt); end
        fifo_rd_count = 16'd4000;
        tick(10);
        checks++; if (state_o !== 2'd2 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL credit_stall got st=%0d rd=%b exp 2/0", state_o, fifo_rd_en); end
        pulse_done();
        checks++; if (credit_cnt !== 4'd1 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL credit_ret got cr=%0d rd=%b exp 1/0", credit_cnt, fifo_rd_en); end
        tick();
        checks++; if (fifo_rd_en !== 1'b1 || credit_cnt !== 4'd0) begin errors++; $display("FAIL credit_go got rd=%b cr=%0d exp 1/0", fifo_rd_en, credit_cnt); end
        run_burst();
        checks++; if (b_rd !== H || line_cnt !== 11'd3) begin errors++; $display("FAIL line2 got rd=%0d lc=%0d exp %0d/3", b_rd, line_cnt, H); end
    endtask

    task automatic test_frame();
        pulse_done();
        tick();
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL line3_go got %b exp 1", fifo_rd_en); end
        fifo_rd_count = 16'd100;
        run_burst();
        checks++; if (b_fe !== 1 || b_fs !== 0 || b_le_ok !== 1) begin errors++; $display("FAIL frame_end got fe=%0d fs=%0d le=%0d exp 1/0/1", b_fe, b_fs, b_le_ok); end
        checks++; if (state_o !== 2'd1 || line_cnt !== 11'd0) begin errors++; $display("FAIL frame_wrap got st=%0d lc=%0d exp 1/0", state_o, line_cnt); end
        tick(20);
        checks++; if (state_o !== 2'd1 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reprime got st=%0d rd=%b exp 1/0", state_o, fifo_rd_en); end
        pulse_done();
        tick();
        pulse_done();
        checks++; if (credit_cnt !== 4'd2 || credit_err !== 1'b0) begin errors++; $display("FAIL credit_refill got cr=%0d ce=%b exp 2/0", credit_cnt, credit_err); end
        fifo_rd_count = 16'd3000;
        tick(2);
        checks++; if (fifo_rd_en !== 1'b1 || credit_cnt !== 4'd1) begin errors++; $display("FAIL frame2_go got rd=%b cr=%0d exp 1/1", fifo_rd_en, credit_cnt); end
        fifo_rd_count = 16'd100;
        run_burst();
        checks++; if (b_fs !== 1 || b_rd !== H || line_cnt !== 11'd1) begin errors++; $display("FAIL frame2_l0 got fs=%0d rd=%0d lc=%0d exp 1/%0d/1", b_fs, b_rd, line_cnt, H); end
    endtask

    task automatic test_errors();
        int n;
        fifo_rd_count = 16'd3000;
        tick();
        fifo_rd_count = 16'd100;
        n = 0;
        while (fifo_rd_en && n < 2000) begin
            fifo_empty = (n == 100);
            tick();
            n++;
        end
        fifo_empty = 1'b0;
        checks++; if (n !== H) begin errors++; $display("FAIL underflow_len got %0d exp %0d", n, H); end
        tick(5);
        checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_flag got %b exp 1", underflow_err); end
        pulse_done();
        tick();
        pulse_done();
        checks++; if (credit_cnt !== 4'd2 || credit_err !== 1'b0) begin errors++; $display("FAIL credit_full got cr=%0d ce=%b exp 2/0", credit_cnt, credit_err); end
        pulse_done();
        checks++; if (credit_cnt !== 4'd2 || credit_err !== 1'b1) begin errors++; $display("FAIL credit_over got cr=%0d ce=%b exp 2/1", credit_cnt, credit_err); end
    endtask

    task automatic test_enable_drop();
        int n;
        fifo_rd_count = 16'd3000;
        tick();
        n = 0;
        while (fifo_rd_en && n < 2000) begin
            if (n == 5) begin
                enable = 1'b0;
                fifo_rd_count = 16'd100;
            end
            tick();
            n++;
        end
        checks++; if (n !== H) begin errors++; $display("FAIL en_drop_len got %0d exp %0d", n, H); end
        tick();
        checks++; if (state_o !== 2'd0 || line_cnt !== 11'd3) begin errors++; $display("FAIL en_drop_idle got st=%0d lc=%0d exp 0/3", state_o, line_cnt); end
    endtask

    task automatic test_rst_mid_burst();
        enable = 1'b1;
        tick();
        fifo_rd_count = 16'd3000;
        tick(2);
        checks++; if (fifo_rd_en !== 1'b1 || credit_cnt !== 4'd0) begin errors++; $display("FAIL rst_pre got rd=%b cr=%0d exp 1/0", fifo_rd_en, credit_cnt); end
        tick(300);
        checks++; if (fifo_rd_en !== 1'b1 || pix_valid !== 1'b1) begin errors++; $display("FAIL rst_mid got rd=%b pv=%b exp 1/1", fifo_rd_en, pix_valid); end
        sys_rst = 1'b1;
        tick();
        checks++; if (fifo_rd_en !== 1'b0 || pix_valid !== 1'b0) begin errors++; $display("FAIL rst_rd got rd=%b pv=%b exp 0/0", fifo_rd_en, pix_valid); end
        checks++; if (credit_cnt !== 4'd2 || state_o !== 2'd0 || line_cnt !== 11'd0) begin errors++; $display("FAIL rst_ctl got cr=%0d st=%0d lc=%0d exp 2/0/0", credit_cnt, state_o, line_cnt); end
        checks++; if ({underflow_err, credit_err} !== 2'b00) begin errors++; $display("FAIL rst_err got %b exp 00", {underflow_err, credit_err}); end
        sys_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prime();
        test_burst();
        test_credit();
        test_frame();
        test_errors();
        test_enable_drop();
        test_rst_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
